// File: rtl/core_pkg.sv
// Core-wide widths and the reorder-buffer entry record shared by the
// reservation stations and debug tooling.
package core_pkg;

    localparam int REG_SIZE     = 64;
    localparam int GPR_COUNT    = 32;
    localparam int GPR_IDX_SIZE = $clog2(GPR_COUNT);

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic [GPR_IDX_SIZE-1:0] gpr_index;
        logic [REG_SIZE-1:0]     value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of dispatch, writeback, operand-lookup and commit signals of the
// reorder buffer. The ROB itself is the slave; the surrounding core is the master.
interface reorder_buffer_if
    import core_pkg::*;
#(
    parameter int ROB_SIZE = 8
);
    localparam int TAG_W = $clog2(ROB_SIZE);

    logic                    i_flush;
    logic                    i_alloc_valid;
    logic [GPR_IDX_SIZE-1:0] i_alloc_gpr;
    logic                    o_alloc_ready;
    logic [TAG_W-1:0]        o_alloc_tag;
    logic                    i_wb_valid;
    logic [TAG_W-1:0]        i_wb_tag;
    logic [REG_SIZE-1:0]     i_wb_value;
    logic [TAG_W-1:0]        i_op1_tag;
    logic                    o_op1_ready;
    logic [REG_SIZE-1:0]     o_op1_value;
    logic [TAG_W-1:0]        i_op2_tag;
    logic                    o_op2_ready;
    logic [REG_SIZE-1:0]     o_op2_value;
    logic                    o_commit;
    logic [TAG_W-1:0]        o_commit_tag;
    logic [GPR_IDX_SIZE-1:0] o_commit_gpr;
    logic [REG_SIZE-1:0]     o_commit_value;
    logic [TAG_W:0]          o_count;

    modport slave (
        input  i_flush, i_alloc_valid, i_alloc_gpr,
        input  i_wb_valid, i_wb_tag, i_wb_value,
        input  i_op1_tag, i_op2_tag,
        output o_alloc_ready, o_alloc_tag,
        output o_op1_ready, o_op1_value, o_op2_ready, o_op2_value,
        output o_commit, o_commit_tag, o_commit_gpr, o_commit_value,
        output o_count
    );

    modport master (
        output i_flush, i_alloc_valid, i_alloc_gpr,
        output i_wb_valid, i_wb_tag, i_wb_value,
        output i_op1_tag, i_op2_tag,
        input  o_alloc_ready, o_alloc_tag,
        input  o_op1_ready, o_op1_value, o_op2_ready, o_op2_value,
        input  o_commit, o_commit_tag, o_commit_gpr, o_commit_value,
        input  o_count
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-bit pointer for the reorder buffer: low TAG_W bits index the entry
// array, the MSB toggles on every wrap so full and empty can be told apart.
module rob_ptr #(
    parameter int TAG_W = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clear,
    input  logic           i_inc,
    output logic [TAG_W:0] o_ptr
);

    logic [TAG_W:0] r_ptr;

    // Clear wins over increment; the entry count is a power of two, so the
    // natural binary roll-over both wraps the index and toggles the wrap bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + {{TAG_W{1'b0}}, 1'b1};
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: dispatch allocates at the tail, functional units
// write results by tag, reservation stations look operands up by tag, and
// completed entries retire from the head one per cycle.
module reorder_buffer
    import core_pkg::*;
#(
    parameter int ROB_SIZE = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    reorder_buffer_if.slave  rob_if
);

    localparam int TAG_W = $clog2(ROB_SIZE);

    logic [TAG_W:0]      w_head;
    logic [TAG_W:0]      w_tail;
    logic [TAG_W-1:0]    w_head_idx;
    logic [TAG_W-1:0]    w_tail_idx;
    logic                w_full;
    logic                w_alloc;
    logic                w_commit;
    logic                w_wb_hit;
    rob_entry_t          w_entries [ROB_SIZE];
    rob_entry_t          w_head_entry;

    logic                r_commit;
    logic [TAG_W-1:0]    r_commit_tag;
    logic [GPR_IDX_SIZE-1:0] r_commit_gpr;
    logic [REG_SIZE-1:0] r_commit_value;
    logic [TAG_W:0]      r_count;

    logic [REG_SIZE:0]   w_op1;
    logic [REG_SIZE:0]   w_op2;

    // Lookup result packed as {ready, value}; a same-cycle writeback to a live
    // entry is forwarded so the RS does not wait an extra cycle.
    function automatic logic [REG_SIZE:0] f_lookup(input rob_entry_t e,
                                                   input logic byp,
                                                   input logic [REG_SIZE-1:0] wb_value);
        if (byp) begin
            return {1'b1, wb_value};
        end else if (e.valid && e.done) begin
            return {1'b1, e.value};
        end
        return '0;
    endfunction

    assign w_head_idx   = w_head[TAG_W-1:0];
    assign w_tail_idx   = w_tail[TAG_W-1:0];
    assign w_full       = (w_head_idx == w_tail_idx) && (w_head[TAG_W] != w_tail[TAG_W]);
    assign w_head_entry = w_entries[w_head_idx];

    // Readiness depends only on registered state, so a same-cycle commit never
    // frees a slot for that cycle's allocation.
    assign w_alloc  = rob_if.i_alloc_valid && !w_full && !rob_if.i_flush;
    assign w_commit = w_head_entry.valid && w_head_entry.done && !rob_if.i_flush;
    assign w_wb_hit = rob_if.i_wb_valid && w_entries[rob_if.i_wb_tag].valid && !rob_if.i_flush;

    rob_ptr #(.TAG_W(TAG_W)) u_head_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (rob_if.i_flush),
        .i_inc   (w_commit),
        .o_ptr   (w_head)
    );

    rob_ptr #(.TAG_W(TAG_W)) u_tail_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (rob_if.i_flush),
        .i_inc   (w_alloc),
        .o_ptr   (w_tail)
    );

    generate
        for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
            rob_entry_t r_entry;

            // Per-entry state: allocation cannot collide with writeback or
            // commit on the same slot (that slot is free), so only the
            // writeback/commit pair needs to coexist.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_entry <= '0;
                end else if (rob_if.i_flush) begin
                    r_entry.valid <= 1'b0;
                    r_entry.done  <= 1'b0;
                end else if (w_alloc && (w_tail_idx == TAG_W'(gi))) begin
                    r_entry.valid     <= 1'b1;
                    r_entry.done      <= 1'b0;
                    r_entry.gpr_index <= rob_if.i_alloc_gpr;
                    r_entry.value     <= '0;
                end else begin
                    if (w_wb_hit && (rob_if.i_wb_tag == TAG_W'(gi))) begin
                        r_entry.done  <= 1'b1;
                        r_entry.value <= rob_if.i_wb_value;
                    end
                    if (w_commit && (w_head_idx == TAG_W'(gi))) begin
                        r_entry.valid <= 1'b0;
                    end
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    // Commit strobe and retire data; the data holds between retirements.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_commit       <= 1'b0;
            r_commit_tag   <= '0;
            r_commit_gpr   <= '0;
            r_commit_value <= '0;
        end else if (w_commit) begin
            r_commit       <= 1'b1;
            r_commit_tag   <= w_head_idx;
            r_commit_gpr   <= w_head_entry.gpr_index;
            r_commit_value <= w_head_entry.value;
        end else begin
            r_commit <= 1'b0;
        end
    end

    // Occupancy: allocation and retirement in the same cycle cancel out.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (rob_if.i_flush) begin
            r_count <= '0;
        end else if (w_alloc && !w_commit) begin
            r_count <= r_count + {{TAG_W{1'b0}}, 1'b1};
        end else if (w_commit && !w_alloc) begin
            r_count <= r_count - {{TAG_W{1'b0}}, 1'b1};
        end
    end

    // Two independent operand ports for the reservation stations.
    always_comb begin
        w_op1 = f_lookup(w_entries[rob_if.i_op1_tag],
                         rob_if.i_wb_valid && (rob_if.i_wb_tag == rob_if.i_op1_tag)
                             && w_entries[rob_if.i_op1_tag].valid,
                         rob_if.i_wb_value);
        w_op2 = f_lookup(w_entries[rob_if.i_op2_tag],
                         rob_if.i_wb_valid && (rob_if.i_wb_tag == rob_if.i_op2_tag)
                             && w_entries[rob_if.i_op2_tag].valid,
                         rob_if.i_wb_value);
    end

    assign rob_if.o_alloc_ready  = !w_full;
    assign rob_if.o_alloc_tag    = w_tail_idx;
    assign rob_if.o_op1_ready    = w_op1[REG_SIZE];
    assign rob_if.o_op1_value    = w_op1[REG_SIZE-1:0];
    assign rob_if.o_op2_ready    = w_op2[REG_SIZE];
    assign rob_if.o_op2_value    = w_op2[REG_SIZE-1:0];
    assign rob_if.o_commit       = r_commit;
    assign rob_if.o_commit_tag   = r_commit_tag;
    assign rob_if.o_commit_gpr   = r_commit_gpr;
    assign rob_if.o_commit_value = r_commit_value;
    assign rob_if.o_count        = r_count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios followed by random traffic,
// all checked against a program-order queue model of the buffer.
module tb_reorder_buffer;
    import core_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_SIZE(N)) rob_if ();

    reorder_buffer #(.ROB_SIZE(N)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .rob_if  (rob_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of live tags in program order plus per-tag state.
    int          q[$];
    bit          m_valid [N];
    bit          m_done  [N];
    logic [4:0]  m_gpr   [N];
    logic [63:0] m_val   [N];
    int          m_tail;
    bit          e_commit;
    int          e_ctag;
    logic [4:0]  e_cgpr;
    logic [63:0] e_cval;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_done[i] = 0; m_gpr[i] = '0; m_val[i] = '0;
        end
        m_tail = 0; e_commit = 0; e_ctag = 0; e_cgpr = '0; e_cval = '0;
    endtask

    task automatic set_in(input bit av, input logic [4:0] g, input bit wv, input int wt,
                          input logic [63:0] wval, input int t1, input int t2, input bit fl);
        rob_if.i_alloc_valid = av;
        rob_if.i_alloc_gpr   = g;
        rob_if.i_wb_valid    = wv;
        rob_if.i_wb_tag      = 3'(wt);
        rob_if.i_wb_value    = wval;
        rob_if.i_op1_tag     = 3'(t1);
        rob_if.i_op2_tag     = 3'(t2);
        rob_if.i_flush       = fl;
    endtask

    task automatic idle();
        set_in(0, 5'd0, 0, 0, 64'd0, 0, 1, 0);
    endtask

    task automatic exp_lookup(input int t, output bit r, output logic [63:0] v);
        bit byp;
        byp = rob_if.i_wb_valid && (int'(rob_if.i_wb_tag) == t) && m_valid[t];
        r = m_valid[t] && (m_done[t] || byp);
        v = byp ? rob_if.i_wb_value : ((m_valid[t] && m_done[t]) ? m_val[t] : 64'd0);
    endtask

    task automatic check_comb(input string ph);
        bit r; logic [63:0] v;
        chk({ph, "_alloc_ready"}, rob_if.o_alloc_ready, q.size() < N);
        chk({ph, "_alloc_tag"}, rob_if.o_alloc_tag, m_tail);
        exp_lookup(int'(rob_if.i_op1_tag), r, v);
        chk({ph, "_op1_ready"}, rob_if.o_op1_ready, r);
        chk({ph, "_op1_value"}, rob_if.o_op1_value, v);
        exp_lookup(int'(rob_if.i_op2_tag), r, v);
        chk({ph, "_op2_ready"}, rob_if.o_op2_ready, r);
        chk({ph, "_op2_value"}, rob_if.o_op2_value, v);
    endtask

    task automatic check_reg(input string ph);
        chk({ph, "_count"}, rob_if.o_count, q.size());
        chk({ph, "_commit"}, rob_if.o_commit, e_commit);
        chk({ph, "_commit_tag"}, rob_if.o_commit_tag, e_ctag);
        chk({ph, "_commit_gpr"}, rob_if.o_commit_gpr, e_cgpr);
        chk({ph, "_commit_value"}, rob_if.o_commit_value, e_cval);
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        bit do_alloc, do_commit;
        int t;
        if (rob_if.i_flush) begin
            for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_done[i] = 0; end
            q.delete(); m_tail = 0; e_commit = 0;
            return;
        end
        do_alloc  = rob_if.i_alloc_valid && (q.size() < N);
        do_commit = (q.size() > 0) && m_done[q[0]];
        e_commit  = do_commit;
        if (do_commit) begin
            e_ctag = q[0]; e_cgpr = m_gpr[q[0]]; e_cval = m_val[q[0]];
        end
        t = int'(rob_if.i_wb_tag);
        if (rob_if.i_wb_valid && m_valid[t]) begin
            m_done[t] = 1; m_val[t] = rob_if.i_wb_value;
        end
        if (do_commit) begin
            m_valid[q[0]] = 0;
            void'(q.pop_front());
        end
        if (do_alloc) begin
            m_valid[m_tail] = 1; m_done[m_tail] = 0;
            m_gpr[m_tail] = rob_if.i_alloc_gpr; m_val[m_tail] = '0;
            q.push_back(m_tail);
            m_tail = (m_tail + 1) % N;
        end
    endtask

    task automatic cycle(input string ph);
        #1;
        check_comb(ph);
        @(posedge clk);
        model_edge();
        #1;
        check_reg(ph);
    endtask

    initial begin
        logic [63:0] rv;
        int          wt;
        model_reset();
        idle();
        #12;
        check_reg("por");
        check_comb("por");
        @(negedge clk);
        rst = 1'b0;

        // 1: reset mid-run with three live entries
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5'(i + 1), 0, 0, 64'd0, 0, 1, 0);
            cycle("t1_alloc");
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_count", rob_if.o_count, 0);
        chk("t1_rst_ready", rob_if.o_alloc_ready, 1);
        chk("t1_rst_tag", rob_if.o_alloc_tag, 0);
        chk("t1_rst_commit", rob_if.o_commit, 0);
        model_reset();
        check_comb("t1_rst");
        @(negedge clk);
        rst = 1'b0;

        // 2: out-of-order writeback, in-order retirement
        set_in(1, 5'd3, 0, 0, 64'd0, 0, 1, 0); cycle("t2_a0");
        set_in(1, 5'd4, 0, 0, 64'd0, 0, 1, 0); cycle("t2_a1");
        set_in(0, 5'd0, 1, 1, 64'h22, 0, 1, 0); cycle("t2_wb1");
        chk("t2_no_commit_a", rob_if.o_commit, 0);
        set_in(0, 5'd0, 1, 0, 64'h11, 0, 1, 0); cycle("t2_wb0");
        chk("t2_no_commit_b", rob_if.o_commit, 0);
        idle(); cycle("t2_c0");
        chk("t2_c0_commit", rob_if.o_commit, 1);
        chk("t2_c0_gpr", rob_if.o_commit_gpr, 3);
        chk("t2_c0_value", rob_if.o_commit_value, 64'h11);
        cycle("t2_c1");
        chk("t2_c1_commit", rob_if.o_commit, 1);
        chk("t2_c1_gpr", rob_if.o_commit_gpr, 4);
        chk("t2_c1_value", rob_if.o_commit_value, 64'h22);
        cycle("t2_c2");
        chk("t2_c2_commit", rob_if.o_commit, 0);

        // 3: fill to capacity, drop the ninth, wrap the tail after one retire
        set_in(0, 5'd0, 0, 0, 64'd0, 0, 1, 1); cycle("t3_flush");
        for (int i = 0; i < N; i++) begin
            set_in(1, 5'(i + 8), 0, 0, 64'd0, 0, 1, 0);
            cycle("t3_fill");
        end
        chk("t3_full_ready", rob_if.o_alloc_ready, 0);
        chk("t3_full_count", rob_if.o_count, 8);
        set_in(1, 5'd31, 0, 0, 64'd0, 0, 1, 0); cycle("t3_ninth");
        chk("t3_ninth_count", rob_if.o_count, 8);
        set_in(0, 5'd0, 1, 0, 64'h100, 0, 1, 0); cycle("t3_wb0");
        idle(); cycle("t3_commit");
        chk("t3_commit_tag", rob_if.o_commit_tag, 0);
        chk("t3_ready_after", rob_if.o_alloc_ready, 1);
        chk("t3_tag_after", rob_if.o_alloc_tag, 0);
        set_in(1, 5'd30, 0, 0, 64'd0, 0, 1, 0); cycle("t3_wrap_alloc");
        chk("t3_wrap_count", rob_if.o_count, 8);

        // 4: same-cycle writeback forwarded to operand lookup
        set_in(0, 5'd0, 1, 2, 64'hDEAD, 2, 3, 0);
        #1;
        chk("t4_byp_ready", rob_if.o_op1_ready, 1);
        chk("t4_byp_value", rob_if.o_op1_value, 64'hDEAD);
        cycle("t4_byp");

        // 5: allocate and retire in the same cycle at count 4
        set_in(0, 5'd0, 0, 0, 64'd0, 0, 1, 1); cycle("t5_flush");
        for (int i = 0; i < 4; i++) begin
            set_in(1, 5'(i + 16), 0, 0, 64'd0, 0, 1, 0);
            cycle("t5_fill");
        end
        set_in(0, 5'd0, 1, 0, 64'h55, 0, 1, 0); cycle("t5_wb");
        chk("t5_count_pre", rob_if.o_count, 4);
        set_in(1, 5'd21, 0, 0, 64'd0, 0, 1, 0); cycle("t5_both");
        chk("t5_count", rob_if.o_count, 4);
        chk("t5_commit_tag", rob_if.o_commit_tag, 0);
        chk("t5_tail", rob_if.o_alloc_tag, 5);

        // 6: flush beats alloc and writeback; a stray writeback afterwards is ignored
        set_in(1, 5'd7, 1, 1, 64'h77, 1, 2, 1); cycle("t6_flush");
        chk("t6_count", rob_if.o_count, 0);
        set_in(0, 5'd0, 1, 1, 64'h99, 1, 2, 0);
        #1;
        chk("t6_stray_ready", rob_if.o_op1_ready, 0);
        cycle("t6_stray");
        chk("t6_count_after", rob_if.o_count, 0);
        idle(); cycle("t6_idle");
        chk("t6_no_commit", rob_if.o_commit, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rv = {$urandom, $urandom};
            if ((q.size() > 0) && ($urandom_range(0, 3) != 0))
                wt = q[$urandom_range(0, q.size() - 1)];
            else
                wt = $urandom_range(0, N - 1);
            set_in($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 1) == 1, wt, rv,
                   $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                   $urandom_range(0, 49) == 0);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
